// File: rtl/tbird_pkg.sv
// Shared state encoding, lamp/segment codes and step-divider helper for the
// T-Bird tail-light controller.
package tbird_pkg;

  typedef logic [3:0] state_t;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_R1   = 4'd1;
  localparam logic [3:0] S_R2   = 4'd2;
  localparam logic [3:0] S_R3   = 4'd3;
  localparam logic [3:0] S_ROFF = 4'd4;
  localparam logic [3:0] S_L1   = 4'd5;
  localparam logic [3:0] S_L2   = 4'd6;
  localparam logic [3:0] S_L3   = 4'd7;
  localparam logic [3:0] S_LOFF = 4'd8;
  localparam logic [3:0] S_ERR  = 4'd9;

  // leds bit order: [5]=LC [4]=LB [3]=LA [2]=RA [1]=RB [0]=RC
  localparam logic [5:0] LED_OFF = 6'b000000;
  localparam logic [5:0] LED_R1  = 6'b000100;
  localparam logic [5:0] LED_R2  = 6'b000110;
  localparam logic [5:0] LED_R3  = 6'b000111;
  localparam logic [5:0] LED_L1  = 6'b001000;
  localparam logic [5:0] LED_L2  = 6'b011000;
  localparam logic [5:0] LED_L3  = 6'b111000;
  localparam logic [5:0] LED_ALL = 6'b111111;

  // active-low, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_R    = 7'b0101111;
  localparam logic [6:0] SEG_L    = 7'b1000111;
  localparam logic [6:0] SEG_E    = 7'b0000110;

  function automatic int step_div(input int clk_hz, input int step_hz);
    return clk_hz / step_hz;
  endfunction

endpackage

// File: rtl/tbird_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer: a new level is
// adopted only after DEBOUNCE_CYCLES consecutive differing samples.
module tbird_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tbird_seq_ctrl.sv
// T-Bird tail-light sequencer: debounced turn requests, step prescaler,
// lamp FSM and registered LED / 7-segment / error outputs.
//
// state | meaning
// IDLE  | no request, lamps dark, prescaler held at 0
// R1-R3 | right sequence, 1..3 right lamps lit
// ROFF  | right sequence dark step, repeats if RIGHT still held
// L1-L3 | left sequence, 1..3 left lamps lit
// LOFF  | left sequence dark step
// ERR   | both switches on, all lamps flash on each tick
module tbird_seq_ctrl
  import tbird_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int STEP_HZ         = 4,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw0,
  input  logic       sw1,
  output logic [5:0] leds,
  output logic [6:0] seg,
  output logic       err
);

  localparam int STEP_DIV = step_div(CLK_HZ, STEP_HZ);
  localparam int PW       = $clog2(STEP_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

  logic          req_r;
  logic          req_l;
  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic          presc_clr;
  logic          lit;
  logic          lit_nxt;
  logic [5:0]    leds_nxt;
  logic [6:0]    seg_nxt;

  tbird_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk(clk), .rst_n(rst_n), .raw(sw0), .level(req_r)
  );

  tbird_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk(clk), .rst_n(rst_n), .raw(sw1), .level(req_l)
  );

  // presc is forced to 0 in IDLE, so tick can never fire there
  assign tick = (presc == PRE_LAST);

  always_comb begin
    state_nxt = state;
    presc_clr = 1'b0;
    lit_nxt   = lit;
    if (req_r && req_l) begin
      if (state != S_ERR) begin
        state_nxt = S_ERR;
        presc_clr = 1'b1;
        lit_nxt   = 1'b1;
      end else if (tick) begin
        lit_nxt = ~lit;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_r)      state_nxt = S_R1;
          else if (req_l) state_nxt = S_L1;
        end
        S_R1, S_R2, S_R3, S_ROFF: begin
          if (req_l) begin
            state_nxt = S_L1;
            presc_clr = 1'b1;
          end else if (tick) begin
            case (state)
              S_R1:    state_nxt = S_R2;
              S_R2:    state_nxt = S_R3;
              S_R3:    state_nxt = S_ROFF;
              default: state_nxt = req_r ? S_R1 : S_IDLE;
            endcase
          end
        end
        S_L1, S_L2, S_L3, S_LOFF: begin
          if (req_r) begin
            state_nxt = S_R1;
            presc_clr = 1'b1;
          end else if (tick) begin
            case (state)
              S_L1:    state_nxt = S_L2;
              S_L2:    state_nxt = S_L3;
              S_L3:    state_nxt = S_LOFF;
              default: state_nxt = req_l ? S_L1 : S_IDLE;
            endcase
          end
        end
        S_ERR: begin
          presc_clr = 1'b1;
          if (req_r)      state_nxt = S_R1;
          else if (req_l) state_nxt = S_L1;
          else            state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      presc <= '0;
      lit   <= 1'b0;
    end else begin
      state <= state_nxt;
      lit   <= lit_nxt;
      if (state == S_IDLE || presc_clr || tick) presc <= '0;
      else                                      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    leds_nxt = LED_OFF;
    seg_nxt  = SEG_ZERO;
    case (state)
      S_R1:   begin leds_nxt = LED_R1;  seg_nxt = SEG_R; end
      S_R2:   begin leds_nxt = LED_R2;  seg_nxt = SEG_R; end
      S_R3:   begin leds_nxt = LED_R3;  seg_nxt = SEG_R; end
      S_ROFF: seg_nxt = SEG_R;
      S_L1:   begin leds_nxt = LED_L1;  seg_nxt = SEG_L; end
      S_L2:   begin leds_nxt = LED_L2;  seg_nxt = SEG_L; end
      S_L3:   begin leds_nxt = LED_L3;  seg_nxt = SEG_L; end
      S_LOFF: seg_nxt = SEG_L;
      S_ERR:  begin leds_nxt = lit ? LED_ALL : LED_OFF; seg_nxt = SEG_E; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= LED_OFF;
      seg  <= SEG_ZERO;
      err  <= 1'b0;
    end else begin
      leds <= leds_nxt;
      seg  <= seg_nxt;
      err  <= (state == S_ERR);
    end
  end

endmodule
